// File: rtl/tnn_decompress_if.sv
// tnn_decompress_if: input-word and decoded-trit handshake bundle for tnn_decompress
interface tnn_decompress_if #(
    parameter int WORD_BYTES = 4
);
    localparam int NB_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [8*WORD_BYTES-1:0] in_data_i;
    logic [NB_W-1:0]         in_nbytes_i;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [9:0]              out_trits_o;
    logic                    out_err_o;
    logic                    out_last_o;
    logic                    out_valid_o;
    logic                    out_ready_i;

    modport master (
        output in_data_i, in_nbytes_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_trits_o, out_err_o, out_last_o, out_valid_o
    );

    modport slave (
        input  in_data_i, in_nbytes_i, in_valid_i, out_ready_i,
        output in_ready_o, out_trits_o, out_err_o, out_last_o, out_valid_o
    );
endinterface

// File: rtl/tnn_decompress.sv
// tnn_decompress: unpacks base-3 compressed bytes into five ternary weights per cycle
module tnn_decompress #(
    parameter int WORD_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    tnn_decompress_if.slave      bus,
    output logic [15:0]          err_cnt_o
);
    localparam int NB_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                  r_state;
    logic [8*WORD_BYTES-1:0] r_word;
    logic [NB_W-1:0]         r_nb;
    logic [NB_W-1:0]         r_k;
    logic [15:0]             r_err_cnt;

    logic       w_valid;
    logic [7:0] w_byte;
    logic       w_err;
    logic       w_last;
    logic       w_out_fire;
    logic       w_in_ready;
    logic       w_in_fire;
    logic [7:0] w_rem;
    logic [7:0] w_dig;
    logic [9:0] w_dec;

    // Output validity is the EMIT state itself, so reset and clear drop it directly
    assign w_valid    = (r_state == EMIT);
    assign w_byte     = 8'(r_word >> {r_k, 3'b000});
    assign w_err      = w_valid && (w_byte >= 8'd243);
    assign w_last     = w_valid && (r_k == r_nb);
    assign w_out_fire = w_valid && bus.out_ready_i;
    assign w_in_ready = !clear_i && (!w_valid || (w_out_fire && w_last));
    assign w_in_fire  = bus.in_valid_i && w_in_ready;

    // Base-3 digit extraction by constant divide, unrolled into one combinational stage
    always_comb begin
        w_rem = w_byte;
        w_dig = '0;
        w_dec = '0;
        for (int i = 0; i < 5; i++) begin
            w_dig = w_rem % 8'd3;
            w_dec[2*i +: 2] = (w_dig == 8'd0) ? 2'b11 : (w_dig == 8'd1) ? 2'b00 : 2'b01;
            w_rem = w_rem / 8'd3;
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = w_valid;
    assign bus.out_err_o   = w_err;
    assign bus.out_last_o  = w_last;
    assign bus.out_trits_o = (w_valid && !w_err) ? w_dec : 10'h000;
    assign err_cnt_o       = r_err_cnt;

    // Word capture, byte stepping and saturating error count; a new word may replace the last byte in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_word    <= '0;
            r_nb      <= '0;
            r_k       <= '0;
            r_err_cnt <= '0;
        end else if (clear_i) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_out_fire && w_err && r_err_cnt != 16'hFFFF)
                r_err_cnt <= r_err_cnt + 16'd1;
            if (w_in_fire) begin
                r_word  <= bus.in_data_i;
                r_nb    <= bus.in_nbytes_i;
                r_k     <= '0;
                r_state <= EMIT;
            end else if (w_out_fire) begin
                if (w_last)
                    r_state <= IDLE;
                else
                    r_k <= r_k + NB_W'(1);
            end
        end
    end
endmodule
